// File: rtl/l1_rd_arbiter_pkg.sv
// l1_rd_arbiter_pkg: shared FSM encodings and AXI burst type constants for the L1 read arbiter.
package l1_rd_arbiter_pkg;
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_ADDR = 2'd1;
  localparam logic [1:0] ARB_DATA = 2'd2;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
endpackage

// File: rtl/l1_rd_arbiter_if.sv
// l1_rd_arbiter_if: L1-side read request/response channels plus the shared L2 read port.
interface l1_rd_arbiter_if #(parameter int MST = 2, parameter int AW = 32, parameter int DW = 64);
  logic [MST*AW-1:0] m_araddr;
  logic [MST*8-1:0]  m_arlen;
  logic [MST*2-1:0]  m_arburst;
  logic [MST-1:0]    m_arvalid;
  logic [MST-1:0]    m_arready;
  logic [DW-1:0]     m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic [MST-1:0]    m_rvalid;
  logic [MST-1:0]    m_rready;
  logic [AW-1:0]     l2_araddr;
  logic [7:0]        l2_arlen;
  logic [1:0]        l2_arburst;
  logic              l2_arvalid;
  logic              l2_arready;
  logic [DW-1:0]     l2_rdata;
  logic [1:0]        l2_rresp;
  logic              l2_rlast;
  logic              l2_rvalid;
  logic              l2_rready;
  modport slave (
    input  m_araddr, m_arlen, m_arburst, m_arvalid, m_rready,
           l2_arready, l2_rdata, l2_rresp, l2_rlast, l2_rvalid,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
           l2_araddr, l2_arlen, l2_arburst, l2_arvalid, l2_rready
  );
  modport master (
    output m_araddr, m_arlen, m_arburst, m_arvalid, m_rready,
           l2_arready, l2_rdata, l2_rresp, l2_rlast, l2_rvalid,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
           l2_araddr, l2_arlen, l2_arburst, l2_arvalid, l2_rready
  );
endinterface

// File: rtl/l1_rd_arbiter_rr_pick.sv
// l1_rd_arbiter_rr_pick: one-hot grant to the first requester at or after ptr, wrapping.
module l1_rd_arbiter_rr_pick #(parameter int N = 2, parameter int PW = 1) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic [N-1:0] rot, first;
  always_comb begin
    rot = N'({req, req} >> ptr);
    first = rot & (~rot + N'(1));
    grant = N'({first, first} >> (N - int'(ptr)));
  end
endmodule

// File: rtl/l1_rd_arbiter.sv
// l1_rd_arbiter: non-preemptive burst arbiter of MST L1 refill masters onto one L2 read port.
// Define RD_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module l1_rd_arbiter
  import l1_rd_arbiter_pkg::*;
#(
  parameter int MST = 2,
  parameter int AW  = 32
) (
  input logic clk,
  input logic rst,
  l1_rd_arbiter_if.slave bus
);
  localparam int PW = MST > 1 ? $clog2(MST) : 1;
  logic [1:0]     state;
  logic [PW-1:0]  owner, ptr, win;
  logic [MST-1:0] grant;
  logic           done;
  l1_rd_arbiter_rr_pick #(.N(MST), .PW(PW)) u_pick (.req(bus.m_arvalid), .ptr(ptr), .grant(grant));
  always_comb begin
    win = '0;
    for (int i = 0; i < MST; i++) win = grant[i] ? PW'(i) : win;
    bus.m_arready = (state == ARB_IDLE) ? grant : '0;
    bus.m_rvalid = (state == ARB_DATA && bus.l2_rvalid) ? MST'(1) << owner : '0;
    bus.l2_rready = (state == ARB_DATA) && bus.m_rready[owner];
    bus.l2_arvalid = (state == ARB_ADDR);
    bus.m_rdata = bus.l2_rdata;
    bus.m_rresp = bus.l2_rresp;
    bus.m_rlast = bus.l2_rlast;
    done = bus.l2_rvalid && bus.l2_rready && bus.l2_rlast;
  end
`ifdef RD_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (done) ptr <= (owner == PW'(MST - 1)) ? '0 : owner + PW'(1);
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      owner <= '0;
      bus.l2_araddr <= '0;
      bus.l2_arlen <= '0;
      bus.l2_arburst <= '0;
    end else if (state == ARB_IDLE && |bus.m_arvalid) begin
      state <= ARB_ADDR;
      owner <= win;
      bus.l2_araddr <= bus.m_araddr[AW*win +: AW];
      bus.l2_arlen <= bus.m_arlen[8*win +: 8];
      bus.l2_arburst <= bus.m_arburst[2*win +: 2];
    end else if (state == ARB_ADDR && bus.l2_arready) begin
      state <= ARB_DATA;
    end else if (state == ARB_DATA && done) begin
      state <= ARB_IDLE;
    end
  end
endmodule

// File: tb/tb_l1_rd_arbiter.sv
// tb_l1_rd_arbiter: directed self-checking bench for l1_rd_arbiter with MST=2.
module tb_l1_rd_arbiter;
  logic clk = 0;
  logic rst = 1;
  int errs = 0;
  int n_chk = 0;
  localparam logic [31:0] A0 = 32'h8000_0040;
  localparam logic [31:0] A1 = 32'h1234_5000;
  l1_rd_arbiter_if #(.MST(2), .AW(32), .DW(64)) bus ();
  l1_rd_arbiter #(.MST(2), .AW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic burst(input logic [1:0] g, input logic [31:0] a, input logic [7:0] len,
                       input logic [1:0] bst, input int beats, input bit drop);
    #1 chk("arready", 64'(bus.m_arready), 64'(g));
    tick;
    if (drop) bus.m_arvalid = bus.m_arvalid & ~g;
    #1;
    chk("l2_arvalid", 64'(bus.l2_arvalid), 64'd1);
    chk("l2_araddr", 64'(bus.l2_araddr), 64'(a));
    chk("l2_arlen", 64'(bus.l2_arlen), 64'(len));
    chk("l2_arburst", 64'(bus.l2_arburst), 64'(bst));
    chk("arready_addr", 64'(bus.m_arready), 64'd0);
    bus.l2_arready = 1;
    tick;
    bus.l2_arready = 0;
    for (int k = 0; k < beats; k++) begin
      bus.l2_rvalid = 1;
      bus.l2_rdata = {a, 32'(k)};
      bus.l2_rlast = (k == beats - 1);
      #1;
      chk("rvalid", 64'(bus.m_rvalid), 64'(g));
      chk("rdata", bus.m_rdata, {a, 32'(k)});
      chk("l2_rready", 64'(bus.l2_rready), 64'd1);
      tick;
    end
    bus.l2_rvalid = 0;
    bus.l2_rlast = 0;
    #1;
    chk("rvalid_idle", 64'(bus.m_rvalid), 64'd0);
    chk("l2_arvalid_idle", 64'(bus.l2_arvalid), 64'd0);
  endtask
  initial begin
    bus.m_araddr = {A1, A0};
    bus.m_arlen = {8'd7, 8'd3};
    bus.m_arburst = {2'd2, 2'd1};
    bus.m_arvalid = 0;
    bus.m_rready = 2'b11;
    bus.l2_arready = 0;
    bus.l2_rdata = 0;
    bus.l2_rresp = 0;
    bus.l2_rlast = 0;
    bus.l2_rvalid = 0;
    #12;
    chk("rst_arready", 64'(bus.m_arready), 64'd0);
    chk("rst_rvalid", 64'(bus.m_rvalid), 64'd0);
    chk("rst_l2_arvalid", 64'(bus.l2_arvalid), 64'd0);
    chk("rst_l2_araddr", 64'(bus.l2_araddr), 64'd0);
    chk("rst_l2_rready", 64'(bus.l2_rready), 64'd0);
    tick;
    rst = 0;
    tick;
    // single master 0 burst of 4 beats
    bus.m_arvalid = 2'b01;
    burst(2'b01, A0, 8'd3, 2'd1, 4, 1);
    // both request continuously; pointer is now 1 after master 0's burst
    bus.m_arvalid = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef RD_ARB_FIXED_PRIO_EN
      burst(2'b01, A0, 8'd3, 2'd1, 1, 0);
`else
      if (i % 2 == 0) burst(2'b10, A1, 8'd7, 2'd2, 1, 0);
      else burst(2'b01, A0, 8'd3, 2'd1, 1, 0);
`endif
    end
    bus.m_arvalid = 0;
    tick;
    // owner stalls RREADY for 3 cycles mid-burst
    bus.m_arvalid = 2'b01;
    #1 chk("stall_arready", 64'(bus.m_arready), 64'd1);
    tick;
    bus.m_arvalid = 0;
    bus.l2_arready = 1;
    tick;
    bus.l2_arready = 0;
    for (int k = 0; k < 4; k++) begin
      bus.l2_rvalid = 1;
      bus.l2_rdata = 64'hD0 + 64'(k);
      bus.l2_rlast = (k == 3);
      if (k == 1) begin
        bus.m_rready = 2'b10;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk("stall_l2_rready", 64'(bus.l2_rready), 64'd0);
          chk("stall_rvalid", 64'(bus.m_rvalid), 64'd1);
          chk("stall_rdata", bus.m_rdata, 64'hD1);
          tick;
        end
        bus.m_rready = 2'b11;
      end
      #1;
      chk("stall_beat_rdata", bus.m_rdata, 64'hD0 + 64'(k));
      chk("stall_beat_l2_rready", 64'(bus.l2_rready), 64'd1);
      tick;
    end
    bus.l2_rvalid = 0;
    bus.l2_rlast = 0;
    // L2_ARREADY held low for 5 cycles with master 0 waiting
    bus.m_araddr = {A1, 32'h8000_1000};
    bus.m_arlen = {8'd7, 8'd1};
    bus.m_arvalid = 2'b10;
    #1 chk("hold_arready", 64'(bus.m_arready), 64'd2);
    tick;
    bus.m_arvalid = 2'b01;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("hold_l2_arvalid", 64'(bus.l2_arvalid), 64'd1);
      chk("hold_l2_araddr", 64'(bus.l2_araddr), 64'(A1));
      chk("hold_l2_arlen", 64'(bus.l2_arlen), 64'd7);
      chk("hold_l2_arburst", 64'(bus.l2_arburst), 64'd2);
      chk("hold_no_arready", 64'(bus.m_arready), 64'd0);
      tick;
    end
    bus.l2_arready = 1;
    tick;
    bus.l2_arready = 0;
    bus.l2_rvalid = 1;
    bus.l2_rlast = 1;
    #1 chk("hold_rvalid", 64'(bus.m_rvalid), 64'd2);
    tick;
    bus.l2_rvalid = 0;
    bus.l2_rlast = 0;
    // master 1 request arrives in master 0's RLAST cycle
    #1 chk("late_arready0", 64'(bus.m_arready), 64'd1);
    tick;
    bus.m_arvalid = 0;
    #1 chk("late_l2_araddr", 64'(bus.l2_araddr), 64'h8000_1000);
    bus.l2_arready = 1;
    tick;
    bus.l2_arready = 0;
    bus.l2_rvalid = 1;
    tick;
    bus.l2_rlast = 1;
    bus.m_arvalid = 2'b10;
    #1;
    chk("late_rlast_arready", 64'(bus.m_arready), 64'd0);
    chk("late_rlast_rvalid", 64'(bus.m_rvalid), 64'd1);
    tick;
    bus.l2_rvalid = 0;
    bus.l2_rlast = 0;
    #1 chk("late_arready1", 64'(bus.m_arready), 64'd2);
    tick;
    bus.m_arvalid = 0;
    #1;
    chk("late_arready_once", 64'(bus.m_arready), 64'd0);
    chk("late_l2_araddr1", 64'(bus.l2_araddr), 64'(A1));
    bus.l2_arready = 1;
    tick;
    bus.l2_arready = 0;
    bus.l2_rvalid = 1;
    bus.l2_rlast = 1;
    tick;
    bus.l2_rvalid = 0;
    bus.l2_rlast = 0;
    // reset pulsed during beat 2 of 4
    bus.m_araddr = {A1, A0};
    bus.m_arlen = {8'd7, 8'd3};
    bus.m_arvalid = 2'b01;
    tick;
    bus.m_arvalid = 0;
    bus.l2_arready = 1;
    tick;
    bus.l2_arready = 0;
    bus.l2_rvalid = 1;
    tick;
    #1 chk("rst_mid_rvalid_pre", 64'(bus.m_rvalid), 64'd1);
    rst = 1;
    #1;
    chk("rst_mid_rvalid", 64'(bus.m_rvalid), 64'd0);
    chk("rst_mid_l2_rready", 64'(bus.l2_rready), 64'd0);
    chk("rst_mid_l2_arvalid", 64'(bus.l2_arvalid), 64'd0);
    chk("rst_mid_l2_araddr", 64'(bus.l2_araddr), 64'd0);
    chk("rst_mid_l2_arlen", 64'(bus.l2_arlen), 64'd0);
    chk("rst_mid_l2_arburst", 64'(bus.l2_arburst), 64'd0);
    chk("rst_mid_arready", 64'(bus.m_arready), 64'd0);
    tick;
    rst = 0;
    #1;
    chk("drop_l2_rready", 64'(bus.l2_rready), 64'd0);
    chk("drop_rvalid", 64'(bus.m_rvalid), 64'd0);
    bus.l2_rvalid = 0;
    tick;
    bus.m_arvalid = 2'b10;
    burst(2'b10, A1, 8'd7, 2'd2, 2, 1);
    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end
endmodule
